// File: rtl/rom_dl_packer_if.sv
// SDRAM word-write port between the ROM download packer (master) and the
// SDRAM controller (slave): level request, one-cycle acknowledge.
interface rom_dl_packer_if #(
  parameter int AW = 25
);
  logic            sdram_req;
  logic            sdram_ack;
  logic [AW-2:0]   sdram_addr;
  logic [15:0]     sdram_din;

  // Handshake: sdram_req is a level held with sdram_addr/sdram_din stable
  // until the slave pulses sdram_ack for one cycle; an ack without req is ignored.
  modport master (
    output sdram_req,
    output sdram_addr,
    output sdram_din,
    input  sdram_ack
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    input  sdram_din,
    output sdram_ack
  );
endinterface

// File: rtl/rom_dl_packer.sv
// Packs data_io download bytes into big-endian 16-bit words, buffers them and
// writes them to SDRAM. Optional macro ROM_DL_CHECKSUM_EN adds a word checksum.
module rom_dl_packer #(
  parameter int          AW         = 25,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                rom_download,
  input  logic                ioctl_wr,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  rom_dl_packer_if.master     sdram,
  output logic                busy,
  output logic                done,
`ifdef ROM_DL_CHECKSUM_EN
  output logic [15:0]         checksum,
`endif
  output logic                overflow,
  output logic [1:0]          wr_state_dbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } wr_state_t;

  wr_state_t        state;

  // Pairing register; a pending entry always carries only the high byte,
  // because an odd byte is pushed immediately.
  logic             pair_v;
  logic [AW-2:0]    pair_addr;
  logic [7:0]       pair_hi;

  logic             dl_q;
  logic             dl_seen;

  logic [AW-2:0]    fifo_addr [FIFO_DEPTH];
  logic [15:0]      fifo_data [FIFO_DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW:0]      fill;
  logic [PW:0]      space;
  logic             fifo_empty;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    wr_idx_nx;
  logic [PW-1:0]    rd_idx;

  logic [AW-2:0]    word_addr;
  logic             same_word;
  logic             byte_ev;
  logic             need_flush;
  logic             need_push;
  logic [PW:0]      need;
  logic             accept;
  logic             end_flush;
  logic             do_flush;
  logic             do_push;
  logic [PW:0]      n_wr;
  logic [15:0]      flush_word;
  logic [15:0]      push_word;
  logic [AW-2:0]    e0_addr;
  logic [15:0]      e0_data;

  assign fill       = wr_ptr - rd_ptr;
  assign space      = (PW+1)'(FIFO_DEPTH) - fill;
  assign fifo_empty = (fill == '0);
  assign wr_idx     = wr_ptr[PW-1:0];
  assign wr_idx_nx  = wr_idx + PW'(1);
  assign rd_idx     = rd_ptr[PW-1:0];

  always_comb begin
    word_addr  = ioctl_addr[AW-1:1];
    same_word  = pair_v && (pair_addr == word_addr);
    byte_ev    = rom_download && ioctl_wr;
    need_flush = pair_v && !same_word;
    need_push  = ioctl_addr[0];
    need       = (PW+1)'(need_flush) + (PW+1)'(need_push);
    // A byte is taken only if every entry it produces fits at once.
    accept     = byte_ev && (need <= space);
    // Pending half-word is flushed one cycle after the window closes.
    end_flush  = !rom_download && !dl_q && pair_v && (space != '0);
    do_flush   = (accept && need_flush) || end_flush;
    do_push    = accept && need_push;
    n_wr       = (PW+1)'(do_flush) + (PW+1)'(do_push);
    flush_word = {pair_hi, PAD_BYTE};
    push_word  = same_word ? {pair_hi, ioctl_dout} : {PAD_BYTE, ioctl_dout};
    e0_addr    = do_flush ? pair_addr  : word_addr;
    e0_data    = do_flush ? flush_word : push_word;
  end

  // Two write ports: the flush (if any) lands first, the push right behind it.
  always_ff @(posedge clk_sys) begin
    if (n_wr != '0) begin
      fifo_addr[wr_idx] <= e0_addr;
      fifo_data[wr_idx] <= e0_data;
    end
    if (n_wr == (PW+1)'(2)) begin
      fifo_addr[wr_idx_nx] <= word_addr;
      fifo_data[wr_idx_nx] <= push_word;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr    <= '0;
      pair_v    <= 1'b0;
      pair_addr <= '0;
      pair_hi   <= '0;
      dl_q      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dl_q   <= rom_download;
      wr_ptr <= wr_ptr + n_wr;
      if (byte_ev && !accept) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        if (!ioctl_addr[0]) begin
          pair_v    <= 1'b1;
          pair_addr <= word_addr;
          pair_hi   <= ioctl_dout;
        end else begin
          pair_v <= 1'b0;
        end
      end else if (end_flush) begin
        pair_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= S_IDLE;
      rd_ptr           <= '0;
      sdram.sdram_req  <= 1'b0;
      sdram.sdram_addr <= '0;
      sdram.sdram_din  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            sdram.sdram_addr <= fifo_addr[rd_idx];
            sdram.sdram_din  <= fifo_data[rd_idx];
            sdram.sdram_req  <= 1'b1;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (sdram.sdram_ack) begin
            rd_ptr          <= rd_ptr + (PW+1)'(1);
            sdram.sdram_req <= 1'b0;
            state           <= S_GAP;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      done    <= 1'b0;
      dl_seen <= 1'b0;
    end else if (rom_download && !dl_q) begin
      done    <= 1'b0;
      dl_seen <= 1'b1;
    end else if (dl_seen && !rom_download && !pair_v && fifo_empty && (state == S_IDLE)) begin
      done <= 1'b1;
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset || (rom_download && !dl_q)) begin
      checksum <= '0;
    end else if ((state == S_REQ) && sdram.sdram_ack) begin
      checksum <= checksum + sdram.sdram_din;
    end
  end
`endif

  assign busy         = !fifo_empty || pair_v || sdram.sdram_req;
  assign wr_state_dbg = state;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Directed plus randomized bench for rom_dl_packer; every SDRAM write is
// scored against an expected queue built from the byte-pairing rules.
module tb_rom_dl_packer;
  localparam int         AW  = 25;
  localparam int         W   = AW - 1 + 16;
  localparam logic [7:0] PAD = 8'hFF;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic           rom_download;
  logic           ioctl_wr;
  logic [AW-1:0]  ioctl_addr;
  logic [7:0]     ioctl_dout;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [1:0]     wr_state_dbg;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0]    checksum;
`endif

  rom_dl_packer_if #(.AW(AW)) sdram ();

  rom_dl_packer #(.AW(AW), .FIFO_DEPTH(4), .PAD_BYTE(8'hFF)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .rom_download (rom_download),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .sdram        (sdram.master),
    .busy         (busy),
    .done         (done),
`ifdef ROM_DL_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .overflow     (overflow),
    .wr_state_dbg (wr_state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  int            n_vec = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW+7:0] bq[$];
  bit            strict = 1'b1;
  bit            ack_hold = 1'b0;
  bit            rand_ack = 1'b0;
  int            fixed_delay = 0;
  int            stray_req = 0;
  int            unstable = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    rom_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    rom_download = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check(tag, done, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Reference: walk the byte list and emit {word addr, {hi, lo}} entries.
  function automatic void model_words();
    logic          pv = 1'b0;
    logic [AW-2:0] pa = '0;
    logic [7:0]    ph = '0;
    logic [AW-1:0] a;
    logic [AW-2:0] wa;
    logic [7:0]    d;
    foreach (bq[i]) begin
      a  = bq[i][AW+7:8];
      d  = bq[i][7:0];
      wa = a[AW-1:1];
      if (!a[0]) begin
        if (pv && pa != wa) exp_q.push_back({pa, ph, PAD});
        pv = 1'b1;
        pa = wa;
        ph = d;
      end else begin
        if (pv && pa == wa) begin
          exp_q.push_back({wa, ph, d});
        end else begin
          if (pv) exp_q.push_back({pa, ph, PAD});
          exp_q.push_back({wa, PAD, d});
        end
        pv = 1'b0;
      end
    end
    if (pv) exp_q.push_back({pa, ph, PAD});
  endfunction

  // SDRAM controller model: ack after a programmable number of req cycles.
  initial begin
    int cnt = 0;
    int cur = 0;
    int stray_seen = 0;
    sdram.sdram_ack = 1'b0;
    forever begin
      tick();
      sdram.sdram_ack = 1'b0;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        sdram.sdram_ack = 1'b1;
      end else if (sdram.sdram_req && !ack_hold && !reset) begin
        if (cnt == 0) cur = rand_ack ? int'($urandom_range(0, 3)) : fixed_delay;
        if (cnt >= cur) begin
          sdram.sdram_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  logic          prev_req = 1'b0;
  logic [AW-2:0] prev_a;
  logic [15:0]   prev_d;
  logic [W-1:0]  exp_w;

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (sdram.sdram_req && prev_req && ({sdram.sdram_addr, sdram.sdram_din} !== {prev_a, prev_d}))
        unstable++;
      if (sdram.sdram_req && sdram.sdram_ack && (strict || exp_q.size() != 0)) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("sdram_write", {sdram.sdram_addr, sdram.sdram_din}, exp_w);
        check("done_low_during_write", done, 0);
      end
      prev_req = sdram.sdram_req && !sdram.sdram_ack;
      prev_a   = sdram.sdram_addr;
      prev_d   = sdram.sdram_din;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    b [12];
    logic [AW+7:0] sendq[$];
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            n;

    reset = 1'b1; rom_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    ticks(3);
    reset = 1'b0;
    check("rst_req", sdram.sdram_req, 0);
    check("rst_addr", sdram.sdram_addr, 0);
    check("rst_din", sdram.sdram_din, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    ticks(5);
    check("rst_done_no_download", done, 0);

    // Contiguous even count, ack two cycles after req
    fixed_delay = 2;
    exp_q.push_back({24'd0, 16'h1234});
    exp_q.push_back({24'd1, 16'h5678});
    start_dl();
    send_byte(0, 8'h12); send_byte(1, 8'h34); send_byte(2, 8'h56); send_byte(3, 8'h78);
    ticks(20);
    check("t2_done_held_while_dl", done, 0);
    end_dl();
    wait_done("t2_done");
    check("t2_overflow", overflow, 0);

    // Odd byte count, last word padded at window close
    fixed_delay = 1;
    exp_q.push_back({24'd0, 16'hAABB});
    exp_q.push_back({24'd1, 16'hCCFF});
    start_dl();
    check("t3_done_cleared", done, 0);
    send_byte(0, 8'hAA); send_byte(1, 8'hBB); send_byte(2, 8'hCC);
    end_dl();
    wait_done("t3_done");

    // Non-contiguous: flush and push in the same cycle
    fixed_delay = 0;
    exp_q.push_back({24'd2, 16'h11FF});
    exp_q.push_back({24'd4, 16'hFF22});
    start_dl();
    send_byte(4, 8'h11); ticks(3); send_byte(9, 8'h22);
    end_dl();
    wait_done("t4_done");

    // Ack held off while 12 back-to-back bytes arrive
    ack_hold = 1'b1;
    strict   = 1'b0;
    foreach (b[i]) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) exp_q.push_back({24'(i), b[2*i], b[2*i+1]});
    start_dl();
    for (int i = 0; i < 12; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = AW'(i); ioctl_dout = b[i];
      tick();
    end
    ioctl_wr = 1'b0;
    ticks(28);
    check("t5_overflow", overflow, 1);
    check("t5_req_held", sdram.sdram_req, 1);
    check("t5_busy", busy, 1);
    check("t5_head_addr", sdram.sdram_addr, 0);
    check("t5_head_din", sdram.sdram_din, {b[0], b[1]});
    ack_hold = 1'b0;
    end_dl();
    wait_done("t5_done");
    strict = 1'b1;
    check("t5_overflow_sticky", overflow, 1);

    // Reset while a request is outstanding
    ack_hold = 1'b1;
    start_dl();
    send_byte(0, 8'h12); send_byte(1, 8'h34);
    n = 0;
    while (sdram.sdram_req !== 1'b1 && n < 20) begin tick(); n++; end
    check("t6_req_up", sdram.sdram_req, 1);
    reset = 1'b1; rom_download = 1'b0;
    tick();
    check("t6_req_after_reset", sdram.sdram_req, 0);
    check("t6_busy_after_reset", busy, 0);
    check("t6_done_after_reset", done, 0);
    check("t6_overflow_after_reset", overflow, 0);
    reset = 1'b0;
    exp_q.delete();
    stray_req++;
    ticks(4);
    check("t6_stray_ack_ignored", sdram.sdram_req, 0);
    check("t6_done_stays_low", done, 0);
    ack_hold = 1'b0;

    // Fresh randomized download from address 0 with random ack latency
    rand_ack = 1'b1;
    a = '0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      bq.push_back({a, d});
      a = a + (($urandom_range(0, 5) == 0) ? AW'($urandom_range(2, 5)) : AW'(1));
    end
    model_words();
    sendq = bq;
    bq.delete();
    start_dl();
    foreach (sendq[i]) begin
      send_byte(sendq[i][AW+7:8], sendq[i][7:0]);
      ticks($urandom_range(6, 8));
    end
    end_dl();
    wait_done("rand_done");
    check("rand_overflow", overflow, 0);

    // All-ones address is a legal last word
    exp_q.push_back({24'hFFFFFF, 16'hABCD});
    start_dl();
    send_byte(25'h1FF_FFFE, 8'hAB); send_byte(25'h1FF_FFFF, 8'hCD);
    end_dl();
    wait_done("top_word_done");

`ifdef ROM_DL_CHECKSUM_EN
    exp_q.push_back({24'd0, 16'hFFFF});
    exp_q.push_back({24'd1, 16'h0002});
    start_dl();
    check("cks_cleared", checksum, 0);
    send_byte(0, 8'hFF); send_byte(1, 8'hFF); send_byte(2, 8'h00); send_byte(3, 8'h02);
    end_dl();
    wait_done("cks_done");
    check("cks_value", checksum, 16'h0001);
`endif

    check("addr_din_stable", unstable, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rom_dl_packer.md
Name: rom_dl_packer

Overview:
- Sits between the data_io byte stream (ioctl_*) and the SDRAM controller write port inside the game top.
- Packs downloaded ROM bytes into 16-bit big-endian words (68000 order) and buffers them in a small FIFO.
- Issues one SDRAM word write per packed word over a req/ack handshake.
- Raises a done flag once every byte of the download has been committed to SDRAM; the core holds reset until then.

Parameters:
- AW, 25, byte address width of ioctl_addr; word address width is AW-1.
- FIFO_DEPTH, 4, number of {word address, data} entries buffered; power of two, minimum 2.
- PAD_BYTE, 8'hFF, filler byte for the missing half of an unpaired word.

Ports:
- clk_sys  in  1  system clock (same clock as data_io).
- reset  in  1  synchronous, active-high reset.
- rom_download  in  1  download window; high while ROM index 0 is streaming.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  AW  byte address of ioctl_dout.
- ioctl_dout  in  8  byte data.
- sdram_req  out  1  write request, level.
- sdram_ack  in  1  one-cycle acknowledge from the SDRAM controller.
- sdram_addr  out  AW-1  word address.
- sdram_din  out  16  word data, {even byte, odd byte}.
- busy  out  1  high while the FIFO or pair register is non-empty, or a request is outstanding.
- done  out  1  sticky; set when a download completes and is fully flushed.
- overflow  out  1  sticky; a byte arrived while the FIFO was full.

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, sdram_din=0, busy=0, done=0, overflow=0. Reset also clears the FIFO and pair register.
- Reset mid-download or mid-request: all state is dropped immediately. sdram_req falls in the same cycle. A late ack is ignored.
- Pairing register holds {valid, word_addr, hi, lo, hi_v, lo_v}.
- Byte with ioctl_wr=1 and address[0]=0:
  - If the register holds a different word, flush it first (missing half = PAD_BYTE).
  - Then load hi.
- Byte with address[0]=1:
  - If the register holds the same word with hi_v, complete and push the word.
  - Else flush the register, then push {PAD_BYTE, byte} for the new word.
- A flush and a push in the same cycle both enter the FIFO, flush first. Two write ports into the FIFO are needed; the FIFO must have 2 free entries for the byte to be accepted.
- Falling edge of rom_download, detected one cycle late: a pending pair register is flushed as padded.
- Byte not accepted because of insufficient space: set overflow and drop the byte; pointers are unchanged. data_io never stalls, so this is an error indication only.
- ioctl_wr while rom_download=0 is ignored.
- Write-side state machine:
  - IDLE: when the FIFO is non-empty, latch the head into sdram_addr/sdram_din, set sdram_req=1 the next cycle, go to REQ.
  - REQ: hold req, addr and data stable until sdram_ack=1. In the ack cycle, pop the FIFO; req=0 the following cycle; go to GAP.
  - GAP: one mandatory idle cycle, then back to IDLE.
  - Minimum spacing is 3 cycles per word. An ack without req is ignored.
- done:
  - Cleared on the rising edge of rom_download.
  - Set one cycle after all of: rom_download low, pair register empty, FIFO empty, state IDLE.
  - Never set at reset unless a download has happened.
- Word address = ioctl_addr[AW-1:1]. No wrap handling: the all-ones address is a legal last word.

Optional Feature:
- Macro: ROM_DL_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (16), the mod-2^16 sum of every sdram_din value, accumulated on each sdram_ack.
  - Cleared at reset and on the rising edge of rom_download.
  - Stable once done=1.
- Undefined: the port and accumulator do not exist; all other behaviour is identical.

Test Plan:
- Bytes 0x12@0, 0x34@1, 0x56@2, 0x78@3 with ack 2 cycles after req -> writes (addr 0, 0x1234), (addr 1, 0x5678); done=1 after rom_download falls; overflow=0.
- Odd count: 0xAA@0, 0xBB@1, 0xCC@2, then rom_download falls -> writes 0xAABB@0, 0xCCFF@1; done=1 only after the second ack.
- Non-contiguous: 0x11@4, then 0x22@9 -> writes 0x11FF@2, 0xFF22@4.
- Ack held off 40 cycles while 12 back-to-back byte strobes arrive (FIFO_DEPTH=4) -> overflow=1, the first 8 bytes (4 words) are written intact, sdram_addr/sdram_din stable while req is high.
- reset pulsed while req is high -> req=0 the next cycle, busy=0, done=0; a subsequent fresh download writes correctly from addr 0.
- With ROM_DL_CHECKSUM_EN: words 0xFFFF and 0x0002 -> checksum=0x0001 when done=1.
